mem_access_unit: RTL and testbench

- MEM-stage data-memory access unit, directly upstream of the WB load-extension logic.
- Converts MEM-stage load/store ops into one-outstanding D-cache requests: word-aligned address, byte strobes, replicated/shifted store data, address-alignment exceptions.
- Stalls the pipeline while a request is in flight.
- Owns the MEM/WB data register feeding WB: raw word WB_DMOut, WB_ALUOut, WB_LoadType, WB_RtData; all sub-word selection/extension is done in WB.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/store_formatter.sv | 44 ++++
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared MEM-stage types: load/store op descriptors, access FSM states, exception codes.
package cpu_pkg;
  localparam int NUM_LANES = 4;

  localparam logic [1:0] SZ_WORD  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_BYTE  = 2'b10;
  localparam logic [1:0] LR_NONE  = 2'b00;
  localparam logic [1:0] LR_RIGHT = 2'b01;
  localparam logic [1:0] LR_LEFT  = 2'b10;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  typedef struct packed {
    logic       sign;
    logic [1:0] size;
    logic [1:0] LeftOrRight;
    logic       ReadMem;
  } LoadType;

  typedef struct packed {
    logic [1:0] size;
    logic [1:0] LeftOrRight;
    logic       DMWr;
  } StoreType;

  typedef enum logic [2:0] {IDLE, WAIT_ACC, WAIT_RESP, DONE, DRAIN} state_e;

  // Unaligned LWL/LWR/SWL/SWR and byte accesses are legal by construction.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lr,
                                      input logic [1:0] a);
    return (lr == LR_NONE) &&
           (((size == SZ_WORD) && (a != 2'b00)) || ((size == SZ_HALF) && a[0]));
  endfunction
endpackage

// File: rtl/store_formatter.sv
// Byte-lane strobes and lane-aligned write data for SB/SH/SW/SWL/SWR.
module store_formatter
  import cpu_pkg::*;
(
  input  logic [1:0]                  a,
  input  logic [1:0]                  size,
  input  logic [1:0]                  lr,
  input  logic [31:0]                 rt,
  output logic [NUM_LANES-1:0]        wstrb,
  output logic [NUM_LANES-1:0][7:0]   wdata
);
  always_comb begin
    wstrb = '0;
    wdata = '0;
    case (lr)
      // SWL writes the high bytes of rt into lanes a..0; SWR the low bytes into lanes 3..a.
      LR_LEFT: begin
        wstrb = 4'b1111 >> (2'd3 - a);
        wdata = rt >> (8 * (2'd3 - a));
      end
      LR_RIGHT: begin
        wstrb = 4'b1111 << a;
        wdata = rt << (8 * a);
      end
      default: begin
        case (size)
          SZ_WORD: begin
            wstrb = 4'b1111;
            wdata = rt;
          end
          SZ_HALF: begin
            wstrb = a[1] ? 4'b1100 : 4'b0011;
            wdata = {2{rt[15:0]}};
          end
          SZ_BYTE: begin
            wstrb = 4'b0001 << a;
            wdata = {4{rt[7:0]}};
          end
          default: ;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage D-cache access unit: one outstanding request, alignment faults,
// and the MEM/WB register carrying the raw loaded word to WB.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_Valid,
  input  logic [ADDR_W-1:0] MEM_ALUOut,
  input  LoadType           MEM_LoadType,
  input  StoreType          MEM_StoreType,
  input  logic [DATA_W-1:0] MEM_RtData,
  input  logic              MEM_Flush,
  input  logic              WB_Stall,
  output logic              MEM_Stall,
  output logic              MEM_ExcValid,
  output logic [4:0]        MEM_ExcCode,
  output logic              dreq_valid,
  input  logic              dreq_ready,
  output logic              dreq_wr,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [3:0]        dreq_wstrb,
  output logic [DATA_W-1:0] dreq_wdata,
  input  logic              dresp_valid,
  input  logic [DATA_W-1:0] dresp_rdata,
  output logic              WB_Valid,
  output logic [DATA_W-1:0] WB_DMOut,
  output logic [ADDR_W-1:0] WB_ALUOut,
  output LoadType           WB_LoadType,
  output logic [DATA_W-1:0] WB_RtData
);
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wstrb;
    logic [DATA_W-1:0] wdata;
  } dreq_t;

  state_e                      state;
  dreq_t                       req_cur, req_q, req_out;
  logic                        drain_pend;
  logic [DATA_W-1:0]           rbuf, rdata_mem, wb_dm;
  logic                        mem_rd, mem_wr, exc_ld, exc_st, exc, op, stall, wb_en;
  logic [NUM_LANES-1:0]        f_wstrb;
  logic [NUM_LANES-1:0][7:0]   f_wdata;

  store_formatter u_fmt (
    .a     (MEM_ALUOut[1:0]),
    .size  (MEM_StoreType.size),
    .lr    (MEM_StoreType.LeftOrRight),
    .rt    (MEM_RtData),
    .wstrb (f_wstrb),
    .wdata (f_wdata)
  );

  always_comb begin
    mem_rd       = MEM_Valid & ~MEM_Flush & MEM_LoadType.ReadMem;
    mem_wr       = MEM_Valid & ~MEM_Flush & MEM_StoreType.DMWr;
    exc_ld       = mem_rd & misaligned(MEM_LoadType.size, MEM_LoadType.LeftOrRight, MEM_ALUOut[1:0]);
    exc_st       = mem_wr & misaligned(MEM_StoreType.size, MEM_StoreType.LeftOrRight, MEM_ALUOut[1:0]);
    exc          = exc_ld | exc_st;
    MEM_ExcValid = exc;
    MEM_ExcCode  = exc_ld ? EXC_ADEL : (exc_st ? EXC_ADES : 5'h00);
    op           = (mem_rd | mem_wr) & ~exc;

    req_cur.wr    = mem_wr;
    req_cur.addr  = {MEM_ALUOut[ADDR_W-1:2], 2'b00};
    req_cur.wstrb = mem_wr ? f_wstrb : 4'b0000;
    req_cur.wdata = mem_wr ? f_wdata : '0;

    dreq_valid = 1'b0;
    req_out    = '0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        dreq_valid = op;
        req_out    = op ? req_cur : '0;
        stall      = op;
      end
      WAIT_ACC: begin
        dreq_valid = 1'b1;
        req_out    = req_q;
        stall      = 1'b1;
      end
      WAIT_RESP: stall = ~dresp_valid;
      // A request already on the bus stays there until accepted, even when flushed.
      DRAIN: begin
        dreq_valid = drain_pend;
        req_out    = drain_pend ? req_q : '0;
        stall      = 1'b1;
      end
      default: ;
    endcase
    {dreq_wr, dreq_addr, dreq_wstrb, dreq_wdata} = req_out;
    MEM_Stall = stall;

    rdata_mem = req_q.wr ? '0 : dresp_rdata;
    wb_dm     = (state == WAIT_RESP) ? rdata_mem : ((state == DONE) ? rbuf : '0);
    wb_en     = ~WB_Stall & ~stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= '0;
      drain_pend  <= 1'b0;
      rbuf        <= '0;
      WB_Valid    <= 1'b0;
      WB_DMOut    <= '0;
      WB_ALUOut   <= '0;
      WB_LoadType <= '0;
      WB_RtData   <= '0;
    end else begin
      // A stalled MEM stage with a free WB inserts a bubble rather than re-retiring.
      if (wb_en) begin
        WB_Valid    <= MEM_Valid & ~MEM_Flush & ~exc;
        WB_DMOut    <= wb_dm;
        WB_ALUOut   <= MEM_ALUOut;
        WB_LoadType <= MEM_LoadType;
        WB_RtData   <= MEM_RtData;
      end else if (!WB_Stall) begin
        WB_Valid <= 1'b0;
      end

      case (state)
        IDLE: if (op) begin
          req_q <= req_cur;
          state <= dreq_ready ? WAIT_RESP : WAIT_ACC;
        end
        WAIT_ACC: begin
          if (MEM_Flush) begin
            state      <= DRAIN;
            drain_pend <= ~dreq_ready;
          end else if (dreq_ready) begin
            state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (dresp_valid) begin
            if (MEM_Flush || !WB_Stall) begin
              state <= IDLE;
            end else begin
              state <= DONE;
              rbuf  <= rdata_mem;
            end
          end else if (MEM_Flush) begin
            state      <= DRAIN;
            drain_pend <= 1'b0;
          end
        end
        DONE: if (!WB_Stall) state <= IDLE;
        DRAIN: begin
          if (drain_pend && dreq_ready) drain_pend <= 1'b0;
          if (dresp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a WB-side scoreboard of expected retirements.
module tb_mem_access_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_Valid;
  logic [31:0] MEM_ALUOut;
  LoadType     MEM_LoadType;
  StoreType    MEM_StoreType;
  logic [31:0] MEM_RtData;
  logic        MEM_Flush, WB_Stall;
  logic        MEM_Stall, MEM_ExcValid;
  logic [4:0]  MEM_ExcCode;
  logic        dreq_valid, dreq_ready, dreq_wr;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_wstrb;
  logic [31:0] dreq_wdata;
  logic        dresp_valid;
  logic [31:0] dresp_rdata;
  logic        WB_Valid;
  logic [31:0] WB_DMOut, WB_ALUOut, WB_RtData;
  LoadType     WB_LoadType;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .MEM_Valid(MEM_Valid), .MEM_ALUOut(MEM_ALUOut), .MEM_LoadType(MEM_LoadType),
    .MEM_StoreType(MEM_StoreType), .MEM_RtData(MEM_RtData), .MEM_Flush(MEM_Flush),
    .WB_Stall(WB_Stall), .MEM_Stall(MEM_Stall), .MEM_ExcValid(MEM_ExcValid),
    .MEM_ExcCode(MEM_ExcCode), .dreq_valid(dreq_valid), .dreq_ready(dreq_ready),
    .dreq_wr(dreq_wr), .dreq_addr(dreq_addr), .dreq_wstrb(dreq_wstrb),
    .dreq_wdata(dreq_wdata), .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
    .WB_Valid(WB_Valid), .WB_DMOut(WB_DMOut), .WB_ALUOut(WB_ALUOut),
    .WB_LoadType(WB_LoadType), .WB_RtData(WB_RtData)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed { logic [31:0] alu; logic [31:0] dm; } wb_exp_t;
  wb_exp_t sb[$];

  typedef struct packed {
    logic [1:0] sz; logic [1:0] lr; logic [31:0] a; logic [31:0] rt;
    logic [3:0] strb; logic [31:0] wd;
  } st_vec_t;
  st_vec_t sv[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic nop();
    MEM_Valid = 1'b0; MEM_Flush = 1'b0; MEM_ALUOut = '0; MEM_RtData = '0;
    MEM_LoadType = '0; MEM_StoreType = '0;
  endtask

  task automatic drive_ld(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] lr);
    MEM_Valid = 1'b1; MEM_Flush = 1'b0; MEM_ALUOut = a; MEM_RtData = 32'h0BAD0BAD;
    MEM_LoadType = {1'b0, sz, lr, 1'b1}; MEM_StoreType = '0;
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] lr,
                          input logic [31:0] rt);
    MEM_Valid = 1'b1; MEM_Flush = 1'b0; MEM_ALUOut = a; MEM_RtData = rt;
    MEM_LoadType = '0; MEM_StoreType = {sz, lr, 1'b1};
  endtask

  // Request accepted at the issue edge; response arrives lat cycles later.
  task automatic finish_req(input logic [31:0] rdata, input int lat);
    step();
    for (int i = 1; i < lat; i++) begin
      chk("stall_wait_resp", MEM_Stall, 1);
      step();
    end
    dresp_valid = 1'b1; dresp_rdata = rdata; #1;
    chk("stall_resp_bypass", MEM_Stall, 0);
    step();
    dresp_valid = 1'b0; dresp_rdata = '0;
    nop();
  endtask

  task automatic wb_pop();
    wb_exp_t e;
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("wb_valid", WB_Valid, 1);
      chk("wb_aluout", WB_ALUOut, e.alu);
      chk("wb_dmout", WB_DMOut, e.dm);
    end
  endtask

  initial begin
    sv[0] = '{SZ_BYTE, LR_NONE,  32'h00001003, 32'h12345678, 4'b1000, 32'h78787878};
    sv[1] = '{SZ_WORD, LR_RIGHT, 32'h00002001, 32'hAABBCCDD, 4'b1110, 32'hBBCCDD00};
    sv[2] = '{SZ_WORD, LR_LEFT,  32'h00002001, 32'hAABBCCDD, 4'b0011, 32'h0000AABB};
    sv[3] = '{SZ_HALF, LR_NONE,  32'h00002002, 32'hAABBCCDD, 4'b1100, 32'hCCDDCCDD};
    sv[4] = '{SZ_WORD, LR_NONE,  32'h00002004, 32'hAABBCCDD, 4'b1111, 32'hAABBCCDD};
    sv[5] = '{SZ_WORD, LR_LEFT,  32'h00002006, 32'hAABBCCDD, 4'b0111, 32'h00AABBCC};
    sv[6] = '{SZ_WORD, LR_RIGHT, 32'h00002007, 32'hAABBCCDD, 4'b1000, 32'hDD000000};

    rst = 1'b1; WB_Stall = 1'b0; dreq_ready = 1'b1; dresp_valid = 1'b0; dresp_rdata = '0;
    nop();
    step(); step();
    chk("rst_stall", MEM_Stall, 0);
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_wb_valid", WB_Valid, 0);
    chk("rst_wb_dmout", WB_DMOut, 0);
    chk("rst_wb_loadtype", WB_LoadType, 0);
    chk("rst_exc", MEM_ExcValid, 0);
    rst = 1'b0;
    step();

    // Non-memory op flows straight to WB with a zero data word.
    MEM_Valid = 1'b1; MEM_ALUOut = 32'h55; #1;
    chk("alu_op_stall", MEM_Stall, 0);
    chk("alu_op_dreq", dreq_valid, 0);
    sb.push_back('{32'h55, 32'h0});
    step(); nop();
    wb_pop();

    // Store formatting table.
    for (int i = 0; i < 7; i++) begin
      drive_st(sv[i].a, sv[i].sz, sv[i].lr, sv[i].rt); #1;
      chk("st_dreq_valid", dreq_valid, 1);
      chk("st_dreq_wr", dreq_wr, 1);
      chk("st_dreq_addr", dreq_addr, {sv[i].a[31:2], 2'b00});
      chk("st_wstrb", dreq_wstrb, sv[i].strb);
      chk("st_wdata", dreq_wdata, sv[i].wd);
      sb.push_back('{sv[i].a, 32'h0});
      finish_req(32'h0, (i == 0) ? 3 : 1);
      wb_pop();
    end

    // LWL at an unaligned address is legal.
    drive_ld(32'h00001003, SZ_WORD, LR_LEFT); #1;
    chk("lwl_exc", MEM_ExcValid, 0);
    chk("lwl_dreq_valid", dreq_valid, 1);
    chk("lwl_addr", dreq_addr, 32'h00001000);
    chk("lwl_wstrb", dreq_wstrb, 4'b0000);
    chk("lwl_wr", dreq_wr, 0);
    sb.push_back('{32'h00001003, 32'h01020304});
    finish_req(32'h01020304, 1);
    wb_pop();

    // Alignment faults.
    drive_ld(32'h00001001, SZ_HALF, LR_NONE); #1;
    chk("lh_exc", MEM_ExcValid, 1);
    chk("lh_code", MEM_ExcCode, 5'h04);
    chk("lh_dreq", dreq_valid, 0);
    chk("lh_stall", MEM_Stall, 0);
    step(); nop();
    chk("lh_wb_valid", WB_Valid, 0);
    drive_st(32'h00001002, SZ_WORD, LR_NONE, 32'h1); #1;
    chk("sw_exc", MEM_ExcValid, 1);
    chk("sw_code", MEM_ExcCode, 5'h05);
    chk("sw_dreq", dreq_valid, 0);
    step(); nop();
    chk("sw_wb_valid", WB_Valid, 0);

    // Backpressured LW, then WB stall parks the result in DONE.
    drive_ld(32'h100, SZ_WORD, LR_NONE); dreq_ready = 1'b0; #1;
    chk("lw_dreq_valid", dreq_valid, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("acc_hold_valid", dreq_valid, 1);
      chk("acc_hold_addr", dreq_addr, 32'h100);
      chk("acc_stall", MEM_Stall, 1);
    end
    dreq_ready = 1'b1;
    step();
    chk("resp_dreq_low", dreq_valid, 0);
    chk("resp_stall", MEM_Stall, 1);
    step(); step();
    WB_Stall = 1'b1; dresp_valid = 1'b1; dresp_rdata = 32'hDEADBEEF; #1;
    chk("lw_stall_bypass", MEM_Stall, 0);
    step();
    dresp_valid = 1'b0; dresp_rdata = '0;
    chk("done_wb_hold", WB_Valid, 0);
    step();
    chk("done_wb_hold2", WB_Valid, 0);
    chk("done_dreq_low", dreq_valid, 0);
    WB_Stall = 1'b0;
    sb.push_back('{32'h100, 32'hDEADBEEF});
    step(); nop();
    wb_pop();

    // Flush in WAIT_RESP: drain, discard data, hold off the next op.
    drive_ld(32'h200, SZ_WORD, LR_NONE); #1;
    step();
    MEM_Flush = 1'b1; #1;
    chk("flush_resp_stall", MEM_Stall, 1);
    step();
    nop(); drive_st(32'h300, SZ_WORD, LR_NONE, 32'h5A5A5A5A); #1;
    chk("drain_no_issue", dreq_valid, 0);
    chk("drain_stall", MEM_Stall, 1);
    step();
    chk("drain_no_issue2", dreq_valid, 0);
    chk("drain_wb_valid", WB_Valid, 0);
    dresp_valid = 1'b1; dresp_rdata = 32'h11111111; #1;
    chk("drain_resp_stall", MEM_Stall, 1);
    step();
    dresp_valid = 1'b0;
    chk("drain_exit_wb_valid", WB_Valid, 0);
    #1;
    chk("post_drain_issue", dreq_valid, 1);
    chk("post_drain_addr", dreq_addr, 32'h300);
    chk("post_drain_wdata", dreq_wdata, 32'h5A5A5A5A);
    sb.push_back('{32'h300, 32'h0});
    finish_req(32'h0, 1);
    wb_pop();

    // Response and flush in the same cycle.
    drive_ld(32'h400, SZ_WORD, LR_NONE); #1;
    step();
    dresp_valid = 1'b1; dresp_rdata = 32'h22222222; MEM_Flush = 1'b1; #1;
    chk("resp_flush_stall", MEM_Stall, 0);
    step();
    dresp_valid = 1'b0; nop(); #1;
    chk("resp_flush_wb_valid", WB_Valid, 0);
    chk("resp_flush_idle", MEM_Stall, 0);

    // Flush while the request is still waiting for acceptance.
    drive_ld(32'h500, SZ_WORD, LR_NONE); dreq_ready = 1'b0; #1;
    step();
    MEM_Flush = 1'b1;
    step();
    nop(); #1;
    chk("drain_hold_valid", dreq_valid, 1);
    chk("drain_hold_addr", dreq_addr, 32'h500);
    dreq_ready = 1'b1;
    step();
    chk("drain_accepted", dreq_valid, 0);
    chk("drain_acc_stall", MEM_Stall, 1);
    dresp_valid = 1'b1;
    step();
    dresp_valid = 1'b0;
    chk("drain2_done_stall", MEM_Stall, 0);
    chk("drain2_wb_valid", WB_Valid, 0);

    // Reset while in WAIT_ACC.
    drive_ld(32'h600, SZ_WORD, LR_NONE); dreq_ready = 1'b0; #1;
    step();
    rst = 1'b1; nop();
    step();
    chk("rst_mid_dreq_valid", dreq_valid, 0);
    chk("rst_mid_dreq_addr", dreq_addr, 0);
    chk("rst_mid_stall", MEM_Stall, 0);
    chk("rst_mid_wb_valid", WB_Valid, 0);
    chk("rst_mid_wb_dmout", WB_DMOut, 0);
    chk("rst_mid_wb_aluout", WB_ALUOut, 0);
    chk("rst_mid_wb_rt", WB_RtData, 0);
    chk("rst_mid_wb_loadtype", WB_LoadType, 0);
    rst = 1'b0; dreq_ready = 1'b1; dresp_valid = 1'b1; dresp_rdata = 32'h33333333;
    step();
    dresp_valid = 1'b0;
    chk("stale_resp_wb_valid", WB_Valid, 0);
    chk("stale_resp_stall", MEM_Stall, 0);
    drive_ld(32'h700, SZ_WORD, LR_NONE); #1;
    chk("post_rst_issue", dreq_valid, 1);
    sb.push_back('{32'h700, 32'hCAFEF00D});
    finish_req(32'hCAFEF00D, 1);
    wb_pop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
